// File: rtl/vexec_unit_if.sv
// Decode/execute inputs and execute/memory outputs of the vector execute stage.
// The master drives the E-stage inputs; the slave (vexec_unit) drives the R-stage outputs.
interface vexec_unit_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned WIDTH = 32
);
    logic                          StartE;
    logic [LANES-1:0][WIDTH-1:0]   RD1E;
    logic [LANES-1:0][WIDTH-1:0]   RD2E;
    logic [WIDTH-1:0]              ExtImmE;
    logic                          ALUSrcE;
    logic [3:0]                    ALUControlE;
    logic [3:0]                    CondE;
    logic [1:0]                    FlagWriteE;
    logic                          RegWriteE;
    logic                          MemWriteE;
    logic                          BranchE;
    logic [3:0]                    WA3E;

    logic                          StallE;
    logic                          DoneR;
    logic [LANES-1:0][WIDTH-1:0]   ResultR;
    logic                          CondExR;
    logic                          RegWriteR;
    logic                          MemWriteR;
    logic                          BranchTakenR;
    logic [3:0]                    WA3R;
    logic [3:0]                    FlagsR;

    modport master (
        output StartE, RD1E, RD2E, ExtImmE, ALUSrcE, ALUControlE, CondE, FlagWriteE,
               RegWriteE, MemWriteE, BranchE, WA3E,
        input  StallE, DoneR, ResultR, CondExR, RegWriteR, MemWriteR, BranchTakenR, WA3R, FlagsR
    );

    modport slave (
        input  StartE, RD1E, RD2E, ExtImmE, ALUSrcE, ALUControlE, CondE, FlagWriteE,
               RegWriteE, MemWriteE, BranchE, WA3E,
        output StallE, DoneR, ResultR, CondExR, RegWriteR, MemWriteR, BranchTakenR, WA3R, FlagsR
    );
endinterface

// File: rtl/vexec_unit.sv
// Vector execute stage: multi-cycle lane-group ALU with NZCV flags and condition evaluation.
// Define VEXEC_MUL_EN to build lane multipliers for opcode 0101; otherwise MUL yields 0.
module vexec_unit #(
    parameter int unsigned LANES           = 16,
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned LANES_PER_CYCLE = 4
) (
    input  logic         CLK,
    input  logic         RST,
    vexec_unit_if.slave  e_io
);
    localparam int unsigned G  = LANES / LANES_PER_CYCLE;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                        state_q, state_d;
    logic [GW-1:0]                 grp_q, grp_d;
    logic [LANES-1:0][WIDTH-1:0]   stage_q, stage_d, result_q;
    logic [3:0]                    nzcv0_q, nzcv0_d, nzcv0_now, nzcv_src;
    logic [3:0]                    flags_q, flags_d;
    logic                          done_q, condex_q, regwrite_q, memwrite_q, branch_q;
    logic [3:0]                    wa3_q;
    logic                          active, last, condex;
    logic [LW-1:0]                 lane_base;
    logic [LANES_PER_CYCLE-1:0][WIDTH+1:0] alu_o;

    // Returns {carry, overflow, result}.
    function automatic logic [WIDTH+1:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [3:0] op);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             c, v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'b0000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: r = a & b;
            4'b0011: r = a | b;
            4'b0100: r = a ^ b;
`ifdef VEXEC_MUL_EN
            4'b0101: r = a * b;
`endif
            4'b0110: r = b;
            4'b0111: r = a << b[4:0];
            4'b1000: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {c, v, r};
    endfunction

    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return c;
            4'b0011: return !c;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return c && !z;
            4'b1001: return !c || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // grp_q is always 0 in StIdle, so it selects the group in both states.
    assign active    = e_io.StartE || (state_q == StBusy);
    assign last      = active && (grp_q == GW'(G - 1));
    assign lane_base = LW'(grp_q) * LW'(LANES_PER_CYCLE);
    assign condex    = cond_holds(e_io.CondE, flags_q);

    for (genvar j = 0; j < LANES_PER_CYCLE; j++) begin : g_lane
        logic [WIDTH-1:0] op_b;
        assign op_b     = e_io.ALUSrcE ? e_io.ExtImmE : e_io.RD2E[lane_base + LW'(j)];
        assign alu_o[j] = alu(e_io.RD1E[lane_base + LW'(j)], op_b, e_io.ALUControlE);
    end

    assign nzcv0_now = {alu_o[0][WIDTH-1], alu_o[0][WIDTH-1:0] == '0,
                        alu_o[0][WIDTH+1], alu_o[0][WIDTH]};
    // Lane 0 lives in group 0; later groups use the copy captured then.
    assign nzcv_src  = (grp_q == '0) ? nzcv0_now : nzcv0_q;

    always_comb begin
        stage_d = stage_q;
        nzcv0_d = nzcv0_q;
        if (active) begin
            for (int j = 0; j < int'(LANES_PER_CYCLE); j++) begin
                stage_d[lane_base + LW'(j)] = alu_o[j][WIDTH-1:0];
            end
            if (grp_q == '0) nzcv0_d = nzcv0_now;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (last && condex) begin
            if (e_io.FlagWriteE[1]) flags_d[3:2] = nzcv_src[3:2];
            if (e_io.FlagWriteE[0]) flags_d[1:0] = nzcv_src[1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        unique case (state_q)
            StIdle: begin
                if (e_io.StartE && !last) begin
                    state_d = StBusy;
                    grp_d   = grp_q + GW'(1);
                end
            end
            StBusy: begin
                if (last) begin
                    state_d = StIdle;
                    grp_d   = '0;
                end else begin
                    grp_d   = grp_q + GW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            grp_q      <= '0;
            stage_q    <= '0;
            nzcv0_q    <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            done_q     <= 1'b0;
            condex_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memwrite_q <= 1'b0;
            branch_q   <= 1'b0;
            wa3_q      <= '0;
        end else begin
            state_q    <= state_d;
            grp_q      <= grp_d;
            stage_q    <= stage_d;
            nzcv0_q    <= nzcv0_d;
            flags_q    <= flags_d;
            done_q     <= last;
            regwrite_q <= last && condex && e_io.RegWriteE;
            memwrite_q <= last && condex && e_io.MemWriteE;
            branch_q   <= last && condex && e_io.BranchE;
            if (last) begin
                result_q <= stage_d;
                condex_q <= condex;
                wa3_q    <= e_io.WA3E;
            end
        end
    end

    // Held in reset, nothing upstream is frozen.
    assign e_io.StallE       = e_io.StartE && !last && !RST;
    assign e_io.DoneR        = done_q;
    assign e_io.ResultR      = result_q;
    assign e_io.CondExR      = condex_q;
    assign e_io.RegWriteR    = regwrite_q;
    assign e_io.MemWriteR    = memwrite_q;
    assign e_io.BranchTakenR = branch_q;
    assign e_io.WA3R         = wa3_q;
    assign e_io.FlagsR       = flags_q;
endmodule

// File: tb/tb_vexec_unit.sv
// Bench for vexec_unit: directed literal checks plus random instructions against a
// whole-instruction reference model compared every cycle.
module tb_vexec_unit;
    localparam int unsigned LANES = 16;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned LPC   = 4;
    localparam int unsigned G     = LANES / LPC;
    localparam int unsigned VW    = LANES * WIDTH;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    vexec_unit_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

    vexec_unit #(.LANES(LANES), .WIDTH(WIDTH), .LANES_PER_CYCLE(LPC)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .e_io (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic c, output logic v);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint t;
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                r = a + b;
                c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
                t = sa + sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                t = sa - sb;
                v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
`ifdef VEXEC_MUL_EN
            4'd5: r = a * b;
`endif
            4'd6: r = b;
            4'd7: r = a << (b % 32);
            4'd8: r = a >> (b % 32);
            default: r = 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0: return z;                 4'd1: return !z;
            4'd2: return c;                 4'd3: return !c;
            4'd4: return n;                 4'd5: return !n;
            4'd6: return v;                 4'd7: return !v;
            4'd8: return c && !z;           4'd9: return !c || z;
            4'd10: return n == v;           4'd11: return n != v;
            4'd12: return !z && (n == v);   4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] opnd_b(input int lane);
        return bus.ALUSrcE ? bus.ExtImmE : bus.RD2E[lane];
    endfunction

    function automatic logic [LANES-1:0][WIDTH-1:0] ref_vec();
        logic [LANES-1:0][WIDTH-1:0] o;
        logic c, v;
        for (int i = 0; i < int'(LANES); i++) ref_alu(bus.ALUControlE, bus.RD1E[i], opnd_b(i), o[i], c, v);
        return o;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [3:0] f);
        logic [31:0] r;
        logic c, v;
        logic [3:0] nf;
        nf = f;
        ref_alu(bus.ALUControlE, bus.RD1E[0], opnd_b(0), r, c, v);
        if (ref_cond(bus.CondE, f)) begin
            if (bus.FlagWriteE[1]) nf[3:2] = {r[31], r == 32'd0};
            if (bus.FlagWriteE[0]) nf[1:0] = {c, v};
        end
        return nf;
    endfunction

    int                          m_phase;   // cycles already spent on the current instruction
    logic                        m_busy;
    logic [3:0]                  m_flags, m_wa3;
    logic                        m_done, m_condex, m_rw, m_mw, m_br;
    logic [LANES-1:0][WIDTH-1:0] m_res;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_phase <= 0; m_busy <= 1'b0; m_flags <= '0; m_wa3 <= '0; m_res <= '0;
            m_done <= 1'b0; m_condex <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_br <= 1'b0;
        end else begin
            m_done <= 1'b0; m_rw <= 1'b0; m_mw <= 1'b0; m_br <= 1'b0;
            if (m_busy || bus.StartE) begin
                if (m_phase == int'(G) - 1) begin
                    m_res    <= ref_vec();
                    m_flags  <= ref_flags(m_flags);
                    m_done   <= 1'b1;
                    m_condex <= ref_cond(bus.CondE, m_flags);
                    m_wa3    <= bus.WA3E;
                    m_rw     <= bus.RegWriteE && ref_cond(bus.CondE, m_flags);
                    m_mw     <= bus.MemWriteE && ref_cond(bus.CondE, m_flags);
                    m_br     <= bus.BranchE && ref_cond(bus.CondE, m_flags);
                    m_phase  <= 0;
                    m_busy   <= 1'b0;
                end else begin
                    m_phase  <= m_phase + 1;
                    m_busy   <= 1'b1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("StallE", bus.StallE, bus.StartE && !RST && (m_phase != int'(G) - 1));
            chk("DoneR", bus.DoneR, m_done);
            chk("ResultR", bus.ResultR, m_res);
            chk("CondExR", bus.CondExR, m_condex);
            chk("RegWriteR", bus.RegWriteR, m_rw);
            chk("MemWriteR", bus.MemWriteR, m_mw);
            chk("BranchTakenR", bus.BranchTakenR, m_br);
            chk("WA3R", bus.WA3R, m_wa3);
            chk("FlagsR", bus.FlagsR, m_flags);
        end
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        bus.ALUSrcE = 1'b0; bus.ExtImmE = '0; bus.CondE = 4'b1110; bus.FlagWriteE = 2'b00;
        bus.RegWriteE = 1'b0; bus.MemWriteE = 1'b0; bus.BranchE = 1'b0; bus.WA3E = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            bus.RD1E[i] = $urandom;
            bus.RD2E[i] = $urandom;
        end
    endtask

    // Holds StartE for one instruction; returns sampled StallE per cycle.
    task automatic run(output logic [G-1:0] st);
        bus.StartE = 1'b1;
        for (int c = 0; c < int'(G); c++) begin
            #1 st[c] = bus.StallE;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        bus.StartE = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [G-1:0] st;
        logic [LANES-1:0][WIDTH-1:0] ev;
        logic [31:0] mul_exp;
        int n;

        bus.StartE = 1'b0;
        bus.ALUControlE = 4'd0;
        clr();
        #2;
        chk("reset DoneR", bus.DoneR, 1'b0);
        chk("reset ResultR", bus.ResultR, '0);
        chk("reset FlagsR", bus.FlagsR, 4'b0000);
        #21 RST = 1'b0;
        cmp_en = 1'b1;
        @(posedge CLK);
        #1;

        // ADD lane i: (i+1) + 2i
        clr();
        bus.ALUControlE = 4'd0;
        for (int i = 0; i < int'(LANES); i++) begin
            bus.RD1E[i] = 32'(i + 1);
            bus.RD2E[i] = 32'(2 * i);
            ev[i]       = 32'(3 * i + 1);
        end
        run(st);
        chk("add stall seq", st, 4'b0111);
        chk("add done", bus.DoneR, 1'b1);
        chk("add result", bus.ResultR, ev);
        chk("add flags held", bus.FlagsR, 4'b0000);

        // SUB 5-5 sets Z,C; then EQ passes, NE fails
        clr();
        bus.ALUControlE = 4'd1; bus.FlagWriteE = 2'b11;
        bus.RD1E[0] = 32'd5; bus.RD2E[0] = 32'd5;
        run(st);
        chk("sub flags", bus.FlagsR, 4'b0110);
        clr();
        bus.ALUControlE = 4'd0; bus.CondE = 4'b0000; bus.RegWriteE = 1'b1; bus.WA3E = 4'd9;
        run(st);
        chk("eq regwrite", bus.RegWriteR, 1'b1);
        chk("eq condex", bus.CondExR, 1'b1);
        chk("eq wa3", bus.WA3R, 4'd9);
        bus.CondE = 4'b0001; bus.FlagWriteE = 2'b11;
        run(st);
        chk("ne regwrite", bus.RegWriteR, 1'b0);
        chk("ne condex", bus.CondExR, 1'b0);
        chk("ne flags held", bus.FlagsR, 4'b0110);

        // Overflow and carry-out
        clr();
        bus.ALUControlE = 4'd0; bus.FlagWriteE = 2'b11;
        bus.RD1E[0] = 32'h7FFF_FFFF; bus.RD2E[0] = 32'h1;
        run(st);
        chk("add ovf flags", bus.FlagsR, 4'b1001);
        bus.RD1E[0] = 32'hFFFF_FFFF; bus.RD2E[0] = 32'h1;
        run(st);
        chk("add carry flags", bus.FlagsR, 4'b0110);
        chk("add carry lane0", bus.ResultR[0], 32'h0);
        idle(2);

        // Reset in cycle 2 of an instruction
        clr();
        bus.ALUControlE = 4'd3;
        bus.StartE = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        chk("rst DoneR", bus.DoneR, 1'b0);
        chk("rst ResultR", bus.ResultR, '0);
        chk("rst FlagsR", bus.FlagsR, 4'b0000);
        chk("rst StallE", bus.StallE, 1'b0);
        @(posedge CLK); #3;
        RST = 1'b0;
        n = 0;
        for (int k = 1; k <= 8 && n == 0; k++) begin
            @(posedge CLK); #1;
            if (bus.DoneR) n = k;
        end
        chk("rst restart latency", 32'(n), 32'd4);
        chk("rst restart result", bus.ResultR[5], bus.RD1E[5] | bus.RD2E[5]);
        idle(1);

        // LSL by 33 shifts by 1; MUL lane 0
        clr();
        bus.ALUControlE = 4'd7; bus.ALUSrcE = 1'b1; bus.ExtImmE = 32'd33;
        bus.RD1E[0] = 32'h8000_0001;
        run(st);
        chk("lsl 33", bus.ResultR[0], 32'h0000_0002);
        clr();
        bus.ALUControlE = 4'd5; bus.FlagWriteE = 2'b11;
        bus.RD1E[0] = 32'd3; bus.RD2E[0] = 32'h4000_0000;
`ifdef VEXEC_MUL_EN
        mul_exp = 32'hC000_0000;
`else
        mul_exp = 32'h0;
`endif
        run(st);
        chk("mul lane0", bus.ResultR[0], mul_exp);

        // Random instructions, sometimes back-to-back, sometimes with gaps
        for (int t = 0; t < 80; t++) begin
            clr();
            bus.ALUControlE = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 8));
            bus.CondE      = 4'($urandom_range(0, 15));
            bus.FlagWriteE = 2'($urandom_range(0, 3));
            bus.RegWriteE  = 1'($urandom);
            bus.MemWriteE  = 1'($urandom);
            bus.BranchE    = 1'($urandom);
            bus.WA3E       = 4'($urandom);
            bus.ALUSrcE    = ($urandom_range(0, 4) == 0);
            bus.ExtImmE    = $urandom;
            if ($urandom_range(0, 3) == 0) bus.RD2E[0] = bus.RD1E[0];
            run(st);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
